// File: rtl/bram_arbiter_pkg.sv
// Shared types for the two-requester BRAM port arbiter: FSM states,
// read-return owner tag and byte-enable width.
package bram_arb_pkg;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef struct packed {
        logic valid;
        logic id;
    } owner_tag_t;

endpackage

// File: rtl/bram_arbiter_rd_tag_pipe.sv
// Shift register carrying the owner tag of each forwarded read so the
// returning data can be steered to the requester that issued it.
module rd_tag_pipe
    import bram_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  owner_tag_t tag_in,
    output owner_tag_t tag_out
);

    owner_tag_t stage_reg [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_reg[i] <= '0;
            end
        end else begin
            stage_reg[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_reg[i] <= stage_reg[i-1];
            end
        end
    end

    assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/bram_arbiter.sv
// Two-requester arbiter for a single BRAM port with round-robin, burst
// preemption, lock and tagged read return. Define ARB_STATS_EN for access counters.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int READ_LAT  = 1,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S0_req,
    input  logic              S0_lock,
    input  logic              S0_R_req,
    input  logic [BE_W-1:0]   S0_W_req,
    input  logic [ADDR_W-1:0] S0_addr,
    input  logic [DATA_W-1:0] S0_W_data,
    output logic              S0_gnt,
    output logic              S0_R_valid,
    output logic [DATA_W-1:0] S0_R_data,
    input  logic              S1_req,
    input  logic              S1_lock,
    input  logic              S1_R_req,
    input  logic [BE_W-1:0]   S1_W_req,
    input  logic [ADDR_W-1:0] S1_addr,
    input  logic [DATA_W-1:0] S1_W_data,
    output logic              S1_gnt,
    output logic              S1_R_valid,
    output logic [DATA_W-1:0] S1_R_data,
    output logic              R_req,
    output logic [BE_W-1:0]   W_req,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] W_data,
    input  logic [DATA_W-1:0] R_data
`ifdef ARB_STATS_EN
    ,
    output logic [31:0]       stat_cnt0,
    output logic [31:0]       stat_cnt1
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t            state_reg, state_next;
    logic              rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]  burst_reg, burst_next;
    logic              fwd0, fwd1;
    logic              burst_full;
    owner_tag_t        tag_in, tag_out;
    logic [1:0]        r_valid;

    assign burst_full = (burst_reg == CNT_W'(MAX_BURST));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (S0_req && S1_req) state_next = rr_ptr_reg ? OWN1 : OWN0;
                else if (S0_req)      state_next = OWN0;
                else if (S1_req)      state_next = OWN1;
            end
            OWN0: begin
                if (!S0_req)                              state_next = S1_req ? OWN1 : IDLE;
                else if (burst_full && S1_req && !S0_lock) state_next = OWN1;
            end
            OWN1: begin
                if (!S1_req)                              state_next = S0_req ? OWN0 : IDLE;
                else if (burst_full && S0_req && !S1_lock) state_next = OWN0;
            end
            default: state_next = IDLE;
        endcase
    end

    // A new grant loads 1 so the counter equals the number of cycles owned
    // so far; preemption therefore happens after exactly MAX_BURST cycles.
    always_comb begin
        burst_next  = burst_reg;
        rr_ptr_next = rr_ptr_reg;
        if (state_next == IDLE) begin
            burst_next = '0;
        end else if (state_next != state_reg) begin
            burst_next  = CNT_W'(1);
            rr_ptr_next = (state_next == OWN0);
        end else if (!burst_full) begin
            burst_next = burst_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b0;
            burst_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            burst_reg  <= burst_next;
        end
    end

    assign S0_gnt = (state_reg == OWN0);
    assign S1_gnt = (state_reg == OWN1);
    assign fwd0   = S0_gnt && S0_req;
    assign fwd1   = S1_gnt && S1_req;

    always_comb begin
        R_req  = 1'b0;
        W_req  = '0;
        addr   = '0;
        W_data = '0;
        if (fwd0) begin
            R_req  = S0_R_req;
            W_req  = S0_W_req;
            addr   = S0_addr;
            W_data = S0_W_data;
        end else if (fwd1) begin
            R_req  = S1_R_req;
            W_req  = S1_W_req;
            addr   = S1_addr;
            W_data = S1_W_data;
        end
    end

    assign tag_in.valid = R_req;
    assign tag_in.id    = fwd1;

    rd_tag_pipe #(
        .DEPTH (READ_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ret
            assign r_valid[gi] = tag_out.valid && (tag_out.id == 1'(gi));
        end
    endgenerate

    assign S0_R_valid = r_valid[0];
    assign S1_R_valid = r_valid[1];
    assign S0_R_data  = R_data;
    assign S1_R_data  = R_data;

`ifdef ARB_STATS_EN
    logic acc0, acc1;
    assign acc0 = fwd0 && (S0_R_req || (|S0_W_req));
    assign acc1 = fwd1 && (S1_R_req || (|S1_W_req));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else begin
            if (acc0 && (stat_cnt0 != 32'hFFFF_FFFF)) stat_cnt0 <= stat_cnt0 + 32'd1;
            if (acc1 && (stat_cnt1 != 32'hFFFF_FFFF)) stat_cnt1 <= stat_cnt1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with READ_LAT=2, MAX_BURST=4 and a
// behavioural memory returning a fixed address-derived word.
module tb_bram_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int READ_LAT  = 2;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              S0_req, S0_lock, S0_R_req;
    logic [3:0]        S0_W_req;
    logic [ADDR_W-1:0] S0_addr;
    logic [DATA_W-1:0] S0_W_data;
    logic              S0_gnt, S0_R_valid;
    logic [DATA_W-1:0] S0_R_data;
    logic              S1_req, S1_lock, S1_R_req;
    logic [3:0]        S1_W_req;
    logic [ADDR_W-1:0] S1_addr;
    logic [DATA_W-1:0] S1_W_data;
    logic              S1_gnt, S1_R_valid;
    logic [DATA_W-1:0] S1_R_data;
    logic              R_req;
    logic [3:0]        W_req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] W_data;
    logic [DATA_W-1:0] R_data;
`ifdef ARB_STATS_EN
    logic [31:0]       stat_cnt0, stat_cnt1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .READ_LAT  (READ_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .S0_req     (S0_req),
        .S0_lock    (S0_lock),
        .S0_R_req   (S0_R_req),
        .S0_W_req   (S0_W_req),
        .S0_addr    (S0_addr),
        .S0_W_data  (S0_W_data),
        .S0_gnt     (S0_gnt),
        .S0_R_valid (S0_R_valid),
        .S0_R_data  (S0_R_data),
        .S1_req     (S1_req),
        .S1_lock    (S1_lock),
        .S1_R_req   (S1_R_req),
        .S1_W_req   (S1_W_req),
        .S1_addr    (S1_addr),
        .S1_W_data  (S1_W_data),
        .S1_gnt     (S1_gnt),
        .S1_R_valid (S1_R_valid),
        .S1_R_data  (S1_R_data),
        .R_req      (R_req),
        .W_req      (W_req),
        .addr       (addr),
        .W_data     (W_data),
        .R_data     (R_data)
`ifdef ARB_STATS_EN
        ,
        .stat_cnt0  (stat_cnt0),
        .stat_cnt1  (stat_cnt1)
`endif
    );

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0] ^ a[31:16], 16'hC0DE};
    endfunction

    logic [DATA_W-1:0] rd_pipe [READ_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= R_req ? mem_word(addr) : '0;
        for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign R_data = rd_pipe[READ_LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %s ok: 0x%0h", tag, got);
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        S0_req = 0; S0_lock = 0; S0_R_req = 0; S0_W_req = 0; S0_addr = 0; S0_W_data = 0;
        S1_req = 0; S1_lock = 0; S1_R_req = 0; S1_W_req = 0; S1_addr = 0; S1_W_data = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int held;
    int stray;

    initial begin
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        check("rst_gnt", {S1_gnt, S0_gnt}, 2'b00);
        check("rst_valid", {S1_R_valid, S0_R_valid}, 2'b00);
        check("rst_mem", {R_req, W_req}, 5'd0);
        rst = 1'b0;

        // Single requester read with latency 2
        S0_req = 1; S0_R_req = 1; S0_addr = 32'h10; #1;
        check("idle_no_fwd", R_req, 1'b0);
        check("idle_gnt0", S0_gnt, 1'b0);
        step();
        check("solo_gnt0", S0_gnt, 1'b1);
        check("solo_rreq", R_req, 1'b1);
        check("solo_addr", addr, 32'h10);
        step();
        S0_R_req = 0;
        check("lat_early", S0_R_valid, 1'b0);
        step();
        check("solo_valid0", S0_R_valid, 1'b1);
        check("solo_data0", S0_R_data, 32'hDEAD_BEEF);
        check("solo_valid1", S1_R_valid, 1'b0);
        step();
        check("solo_valid_end", S0_R_valid, 1'b0);
        S0_req = 0;
        step();
        check("solo_idle", {S1_gnt, S0_gnt}, 2'b00);

        // Simultaneous requests and direct hand-over
        do_reset();
        S0_req = 1; S1_req = 1;
        step();
        check("tie_first", {S1_gnt, S0_gnt}, 2'b01);
        S0_req = 0; S0_R_req = 1; #1;
        check("noreq_mem_zero", R_req, 1'b0);
        step();
        check("handover", {S1_gnt, S0_gnt}, 2'b10);
        clear_inputs();
        step();
        check("handover_idle", {S1_gnt, S0_gnt}, 2'b00);

        // Burst preemption alternates every MAX_BURST cycles
        do_reset();
        S0_req = 1; S1_req = 1;
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("burst_k%0d", k), {S1_gnt, S0_gnt},
                  (((k - 1) / 4) % 2 == 1) ? 2'b10 : 2'b01);
        end
        clear_inputs();
        step();
        check("burst_idle", {S1_gnt, S0_gnt}, 2'b00);
        S0_req = 1; S1_req = 1;
        step();
        check("rr_favours_s1", {S1_gnt, S0_gnt}, 2'b10);
        clear_inputs();
        step();

        // Lock blocks preemption
        do_reset();
        S0_req = 1; S0_lock = 1;
        step();
        S1_req = 1;
        held = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (S0_gnt) held++;
        end
        check("lock_held", held, 40);
        S0_req = 0;
        step();
        check("lock_release", {S1_gnt, S0_gnt}, 2'b10);
        clear_inputs();
        step();

        // Read on last owned cycle returns to S0 after hand-over
        do_reset();
        S0_req = 1; S1_req = 1;
        step(); step(); step(); step();
        check("last_cycle_gnt", {S1_gnt, S0_gnt}, 2'b01);
        S0_R_req = 1; S0_addr = 32'h20; #1;
        check("last_cycle_rreq", R_req, 1'b1);
        step();
        S0_R_req = 0;
        check("preempt_gnt", {S1_gnt, S0_gnt}, 2'b10);
        S1_R_req = 1; S1_W_req = 4'b0101; S1_W_data = 32'h1234_5678; S1_addr = 32'h30; #1;
        check("rw_same_cycle", {R_req, W_req}, 5'b1_0101);
        check("rw_wdata", W_data, 32'h1234_5678);
        step();
        S1_R_req = 0; S1_W_req = 0;
        check("tag_valid", {S1_R_valid, S0_R_valid}, 2'b01);
        check("tag_data0", S0_R_data, 32'h0020_C0DE);
        step();
        check("tag_valid_s1", {S1_R_valid, S0_R_valid}, 2'b10);
        check("tag_data1", S1_R_data, 32'h0030_C0DE);
        clear_inputs();
        step();

        // Reset with a read in flight
        do_reset();
        S1_req = 1;
        step();
        S1_R_req = 1; S1_addr = 32'h10;
        step();
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_gnt", {S1_gnt, S0_gnt}, 2'b00);
        check("async_rst_mem", {R_req, W_req}, 5'd0);
        check("async_rst_valid", {S1_R_valid, S0_R_valid}, 2'b00);
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        stray = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (S0_R_valid || S1_R_valid) stray++;
        end
        check("no_valid_after_rst", stray, 0);

`ifdef ARB_STATS_EN
        do_reset();
        check("stat_rst", stat_cnt1, 32'd0);
        S1_req = 1;
        step();
        S1_W_req = 4'hF; S1_addr = 32'h40; S1_W_data = 32'hA5A5_A5A5;
        for (int k = 0; k < 5; k++) step();
        clear_inputs();
        check("stat_cnt1", stat_cnt1, 32'd5);
        check("stat_cnt0", stat_cnt0, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
